csr_access_sequencer: RTL and testbench

//  Initiator side of the CSR read/write port: executes one Zicsr instruction
//  (CSRRW/S/C, CSRRWI/SI/CI) as a read-modify-write sequence against the CSR

---
 rtl/csr_access_sequencer_if.sv | 28 ++
 rtl/csr_access_sequencer.sv | 168 ++++++++++++++++
 tb/tb_csr_access_sequencer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_access_sequencer_if.sv
// CSR register-file port between the CSR access sequencer (master) and the CSR file (slave).
interface csr_access_sequencer_if #(
  parameter int XLEN          = 32,
  parameter int CSR_ADDR_BITS = 12
);
  // Requests are one-cycle pulses with no back-pressure. A read is answered by
  // read_en_in/read_data_in some cycles later. csr_fault is valid exactly one
  // cycle after a request is issued: alongside read_en_in for a read, and in
  // the cycle after write_enable for a write.
  logic                     read_enable;
  logic [CSR_ADDR_BITS-1:0] read_addr;
  logic                     read_en_in;
  logic [XLEN-1:0]          read_data_in;
  logic                     write_enable;
  logic [CSR_ADDR_BITS-1:0] write_addr;
  logic [XLEN-1:0]          write_data;
  logic                     csr_fault;

  modport master (
    output read_enable, read_addr, write_enable, write_addr, write_data,
    input  read_en_in, read_data_in, csr_fault
  );

  modport slave (
    input  read_enable, read_addr, write_enable, write_addr, write_data,
    output read_en_in, read_data_in, csr_fault
  );
endinterface

// File: rtl/csr_access_sequencer.sv
// Executes one Zicsr instruction as a read-modify-write sequence against the CSR file,
// returning the old CSR value for rd or flagging an illegal access.
module csr_access_sequencer #(
  parameter int XLEN          = 32,
  parameter int CSR_ADDR_BITS = 12,
  parameter int RD_TIMEOUT    = 15
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sync_reset,
  input  logic                     start,
  input  logic                     flush,
  input  logic [2:0]               funct3,
  input  logic [CSR_ADDR_BITS-1:0] csr_addr,
  input  logic [4:0]               rs1_field,
  input  logic [XLEN-1:0]          rs1_value,
  input  logic [4:0]               rd_field,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_we,
  output logic [4:0]               rd_addr,
  output logic [XLEN-1:0]          rd_data,
  output logic                     illegal,
  output logic [CSR_ADDR_BITS-1:0] illegal_addr,
  output logic [2:0]               dbg_state,
  csr_access_sequencer_if.master   csr
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_CHK, S_DONE, S_ILLEGAL
  } state_t;

  localparam int TMO_W = $clog2(RD_TIMEOUT + 1);

  state_t                   state;
  logic [1:0]               op_q;
  logic [CSR_ADDR_BITS-1:0] addr_q;
  logic [XLEN-1:0]          src_q;
  logic [XLEN-1:0]          old_q;
  logic                     do_write_q;
  logic [TMO_W-1:0]         tmo_cnt;

  logic [XLEN-1:0] dec_src;
  logic            dec_read;
  logic            dec_write;
  logic            dec_illegal;

  always_comb begin
    dec_src     = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_field} : rs1_value;
    dec_read    = !(funct3[1:0] == 2'b01 && rd_field == 5'd0);
    dec_write   = (funct3[1:0] == 2'b01) || (rs1_field != 5'd0);
    // Top two address bits 11 mark a read-only CSR.
    dec_illegal = (funct3[1:0] == 2'b00) ||
                  (dec_write && csr_addr[CSR_ADDR_BITS-1 -: 2] == 2'b11);
  end

  function automatic logic [XLEN-1:0] wr_value(input logic [1:0] op,
                                               input logic [XLEN-1:0] old,
                                               input logic [XLEN-1:0] src);
    case (op)
      2'b10:   wr_value = old | src;
      2'b11:   wr_value = old & ~src;
      default: wr_value = src;
    endcase
  endfunction

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;  op_q <= '0;  addr_q <= '0;  src_q <= '0;  old_q <= '0;
      do_write_q <= 1'b0;  tmo_cnt <= '0;
      done <= 1'b0;  rd_we <= 1'b0;  rd_addr <= '0;  rd_data <= '0;
      illegal <= 1'b0;  illegal_addr <= '0;
      csr.read_enable <= 1'b0;  csr.read_addr <= '0;
      csr.write_enable <= 1'b0;  csr.write_addr <= '0;  csr.write_data <= '0;
    end else if (sync_reset) begin
      state <= S_IDLE;  op_q <= '0;  addr_q <= '0;  src_q <= '0;  old_q <= '0;
      do_write_q <= 1'b0;  tmo_cnt <= '0;
      done <= 1'b0;  rd_we <= 1'b0;  rd_addr <= '0;  rd_data <= '0;
      illegal <= 1'b0;  illegal_addr <= '0;
      csr.read_enable <= 1'b0;  csr.read_addr <= '0;
      csr.write_enable <= 1'b0;  csr.write_addr <= '0;  csr.write_data <= '0;
    end else begin
      // Pulse outputs are high only in the cycle of the state that owns them.
      done             <= 1'b0;
      rd_we            <= 1'b0;
      illegal          <= 1'b0;
      csr.read_enable  <= 1'b0;
      csr.write_enable <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            op_q           <= funct3[1:0];
            addr_q         <= csr_addr;
            src_q          <= dec_src;
            do_write_q     <= dec_write;
            old_q          <= '0;
            rd_addr        <= rd_field;
            csr.read_addr  <= csr_addr;
            csr.write_addr <= csr_addr;
            if (dec_illegal) begin
              state        <= S_ILLEGAL;
              illegal      <= 1'b1;
              illegal_addr <= csr_addr;
            end else if (dec_read) begin
              state           <= S_RD_REQ;
              csr.read_enable <= 1'b1;
            end else begin
              state            <= S_WR_REQ;
              csr.write_enable <= 1'b1;
              csr.write_data   <= wr_value(funct3[1:0], '0, dec_src);
            end
          end
        end
        S_RD_REQ: begin
          tmo_cnt <= '0;
          state   <= flush ? S_IDLE : S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (csr.read_en_in) begin
            if (csr.csr_fault) begin
              state        <= S_ILLEGAL;
              illegal      <= 1'b1;
              illegal_addr <= addr_q;
            end else begin
              old_q <= csr.read_data_in;
              if (do_write_q) begin
                state            <= S_WR_REQ;
                csr.write_enable <= 1'b1;
                csr.write_data   <= wr_value(op_q, csr.read_data_in, src_q);
              end else begin
                state   <= S_DONE;
                done    <= 1'b1;
                rd_we   <= (rd_addr != 5'd0);
                rd_data <= csr.read_data_in;
              end
            end
          end else if (tmo_cnt == TMO_W'(RD_TIMEOUT - 1)) begin
            state        <= S_ILLEGAL;
            illegal      <= 1'b1;
            illegal_addr <= addr_q;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_WR_REQ: state <= S_WR_CHK;
        S_WR_CHK: begin
          if (csr.csr_fault) begin
            state        <= S_ILLEGAL;
            illegal      <= 1'b1;
            illegal_addr <= addr_q;
          end else begin
            state   <= S_DONE;
            done    <= 1'b1;
            rd_we   <= (rd_addr != 5'd0);
            rd_data <= old_q;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_access_sequencer.sv
// Self-checking bench for csr_access_sequencer: a CSR-file responder, a spec model
// feeding expected-result/read/write queues, and a negedge monitor that pops and compares.
module tb_csr_access_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sync_reset = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [11:0] csr_addr = '0;
  logic [4:0]  rs1_field = '0;
  logic [31:0] rs1_value = '0;
  logic [4:0]  rd_field = '0;
  logic        busy, done, rd_we, illegal;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [11:0] illegal_addr;
  logic [2:0]  dbg_state;

  csr_access_sequencer_if #(.XLEN(32), .CSR_ADDR_BITS(12)) csr_bus ();

  csr_access_sequencer #(.XLEN(32), .CSR_ADDR_BITS(12), .RD_TIMEOUT(15)) dut (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset), .start(start), .flush(flush),
    .funct3(funct3), .csr_addr(csr_addr), .rs1_field(rs1_field), .rs1_value(rs1_value),
    .rd_field(rd_field), .busy(busy), .done(done), .rd_we(rd_we), .rd_addr(rd_addr),
    .rd_data(rd_data), .illegal(illegal), .illegal_addr(illegal_addr),
    .dbg_state(dbg_state), .csr(csr_bus.master)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [38:0] exp_q[$];
  int          lat_q[$];
  logic [11:0] rexp_q[$];
  logic [43:0] wexp_q[$];
  logic [31:0] exp_mem[int];
  logic [31:0] csr_mem[int];
  int          cur_start = 0;
  logic        stall = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- CSR file responder ----------------
  initial begin
    logic rq, wq;
    logic [11:0] ra, wa;
    logic [31:0] wd;
    csr_bus.read_en_in   = 1'b0;
    csr_bus.read_data_in = '0;
    csr_bus.csr_fault    = 1'b0;
    forever begin
      @(negedge clk);
      rq = csr_bus.read_enable;  ra = csr_bus.read_addr;
      wq = csr_bus.write_enable; wa = csr_bus.write_addr; wd = csr_bus.write_data;
      @(posedge clk);
      #1;
      csr_bus.read_en_in   = rq && !stall;
      csr_bus.read_data_in = (rq && csr_mem.exists(int'(ra))) ? csr_mem[int'(ra)] : 32'hDEAD_BEEF;
      csr_bus.csr_fault    = (rq && !stall && !csr_mem.exists(int'(ra))) ||
                             (wq && !csr_mem.exists(int'(wa)));
      if (wq && csr_mem.exists(int'(wa))) csr_mem[int'(wa)] = wd;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [38:0] obs;
    if (reset_n) begin
      if (csr_bus.read_enable && csr_bus.write_enable) check_eq("req_exclusive", 1, 0);
      if (csr_bus.read_enable) begin
        if (rexp_q.size() == 0) check_eq("unexpected_read", 1, 0);
        else check_eq("read_addr", csr_bus.read_addr, rexp_q.pop_front());
      end
      if (csr_bus.write_enable) begin
        if (wexp_q.size() == 0) check_eq("unexpected_write", 1, 0);
        else check_eq("write_addr_data", {csr_bus.write_addr, csr_bus.write_data}, wexp_q.pop_front());
      end
      if (done && illegal) check_eq("done_with_illegal", 1, 0);
      if (done || illegal) begin
        obs = illegal ? {1'b1, rd_we, 5'd0, 20'd0, illegal_addr} : {1'b0, rd_we, rd_addr, rd_data};
        if (exp_q.size() == 0) check_eq("unexpected_result", obs, 0);
        else begin
          check_eq("result", obs, exp_q.pop_front());
          check_eq("latency", cyc - cur_start, lat_q.pop_front());
        end
      end
    end
  end

  // ---------------- model + driver ----------------
  task automatic model_op(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rs1f,
                          input logic [31:0] rs1v, input logic [4:0] rdf);
    logic [31:0] src, old, wd;
    logic [1:0]  op, ro;
    logic        dr, dw, ill, mapped;
    int          lat;
    op = f3[1:0];
    ro = addr[11:10];
    src = f3[2] ? {27'd0, rs1f} : rs1v;
    dr  = !(op == 2'b01 && rdf == 5'd0);
    dw  = (op == 2'b01) || (rs1f != 5'd0);
    mapped = exp_mem.exists(int'(addr));
    lat = 1; old = '0; ill = 1'b0;
    if (op == 2'b00 || (dw && ro == 2'b11)) ill = 1'b1;
    else begin
      if (dr) begin
        rexp_q.push_back(addr);
        lat += 2;
        if (!mapped) ill = 1'b1; else old = exp_mem[int'(addr)];
      end
      if (!ill && dw) begin
        wd = (op == 2'b01) ? src : (op == 2'b10) ? (old | src) : (old & ~src);
        wexp_q.push_back({addr, wd});
        lat += 2;
        if (!mapped) ill = 1'b1; else exp_mem[int'(addr)] = wd;
      end
    end
    exp_q.push_back(ill ? {1'b1, 1'b0, 5'd0, 20'd0, addr} : {1'b0, rdf != 5'd0, rdf, old});
    lat_q.push_back(lat);
  endtask

  task automatic drive_start(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rs1f,
                             input logic [31:0] rs1v, input logic [4:0] rdf);
    @(posedge clk);
    #1;
    funct3 = f3; csr_addr = addr; rs1_field = rs1f; rs1_value = rs1v; rd_field = rdf;
    start = 1'b1;
    cur_start = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rs1f,
                        input logic [31:0] rs1v, input logic [4:0] rdf, input int flush_at);
    int n;
    model_op(f3, addr, rs1f, rs1v, rdf);
    drive_start(f3, addr, rs1f, rs1v, rdf);
    n = 0;
    while (busy && n < 40) begin
      flush = (cyc - cur_start == flush_at);
      @(posedge clk);
      #1;
      n++;
    end
    flush = 1'b0;
    if (n >= 40) check_eq("op_completion_timeout", 1, 0);
  endtask

  task automatic clear_queues();
    exp_q.delete(); lat_q.delete(); rexp_q.delete(); wexp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [11:0] addr_tab[4];
    logic [2:0]  f3_tab[6];
    logic [4:0]  r1;
    addr_tab = '{12'h340, 12'h304, 12'h7FF, 12'hF11};
    f3_tab   = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
    exp_mem[12'h340] = 32'h0000_1234;  csr_mem[12'h340] = 32'h0000_1234;
    exp_mem[12'h304] = 32'h0000_0080;  csr_mem[12'h304] = 32'h0000_0080;
    exp_mem[12'h305] = 32'h0000_0100;  csr_mem[12'h305] = 32'h0000_0100;
    exp_mem[12'hF11] = 32'h0000_0A5A;  csr_mem[12'hF11] = 32'h0000_0A5A;

    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_busy_done_illegal", {busy, done, rd_we, illegal}, 0);
    check_eq("reset_data_outputs", {rd_addr, rd_data, illegal_addr}, 0);
    check_eq("reset_csr_requests", {csr_bus.read_enable, csr_bus.write_enable,
                                    csr_bus.read_addr, csr_bus.write_addr, csr_bus.write_data}, 0);
    check_eq("reset_state", dbg_state, 0);
    reset_n = 1'b1;

    // Directed Zicsr cases
    run_op(3'b010, 12'h340, 5'd0, 32'h0,  5'd5, -1);  // CSRRS x5,mscratch,x0
    run_op(3'b011, 12'h304, 5'd7, 32'h80, 5'd6, -1);  // CSRRC x6,mie,x7
    run_op(3'b101, 12'h305, 5'd5, 32'h0,  5'd0, -1);  // CSRRWI x0,mtvec,5
    run_op(3'b001, 12'h7FF, 5'd4, 32'hAA, 5'd3, -1);  // CSRRW to unmapped
    run_op(3'b010, 12'hF11, 5'd2, 32'h9,  5'd1, -1);  // write to read-only CSR
    run_op(3'b010, 12'hF11, 5'd0, 32'h9,  5'd1, -1);  // read of read-only CSR
    run_op(3'b000, 12'h340, 5'd1, 32'h1,  5'd1, -1);  // reserved funct3
    run_op(3'b101, 12'h7FF, 5'd3, 32'h0,  5'd0, -1);  // write-only, fault on write
    run_op(3'b010, 12'h340, 5'd9, 32'h0F00_0000, 5'd8, 3);  // flush during WR_REQ ignored
    run_op(3'b010, 12'h340, 5'd0, 32'h0,  5'd2, -1);  // read back committed value

    // Read timeout, with a start pulse while busy that must be ignored
    stall = 1'b1;
    rexp_q.push_back(12'h304);
    exp_q.push_back({1'b1, 1'b0, 5'd0, 20'd0, 12'h304});
    lat_q.push_back(17);
    drive_start(3'b010, 12'h304, 5'd0, 32'h0, 5'd4);
    repeat (3) @(posedge clk);
    #1 start = 1'b1; csr_addr = 12'h340;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_eq("timeout_idle", busy, 0);
    check_eq("timeout_result_drained", exp_q.size(), 0);

    // Flush while waiting for read data
    rexp_q.push_back(12'h304);
    drive_start(3'b010, 12'h304, 5'd0, 32'h0, 5'd4);
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check_eq("flush_rd_wait_idle", busy, 0);
    stall = 1'b0;
    repeat (5) @(posedge clk);

    // Flush together with start in IDLE
    #1;
    funct3 = 3'b010; csr_addr = 12'h340; rs1_field = 5'd0; rd_field = 5'd3;
    start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    check_eq("flush_with_start_idle", busy, 0);
    repeat (3) @(posedge clk);

    // Synchronous reset mid-read
    stall = 1'b1;
    rexp_q.push_back(12'h340);
    drive_start(3'b010, 12'h340, 5'd0, 32'h0, 5'd7);
    @(posedge clk);
    #1 sync_reset = 1'b1;
    @(posedge clk);
    #1 sync_reset = 1'b0;
    check_eq("sync_reset_idle", {busy, dbg_state}, 0);
    check_eq("sync_reset_latches", {rd_addr, rd_data, illegal_addr}, 0);
    stall = 1'b0;
    repeat (3) @(posedge clk);

    // Asynchronous reset while the read request is on the bus
    rexp_q.push_back(12'h304);
    @(posedge clk);
    #1;
    funct3 = 3'b010; csr_addr = 12'h304; rs1_field = 5'd0; rd_field = 5'd2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    reset_n = 1'b0;
    #1;
    check_eq("async_reset_requests", {csr_bus.read_enable, csr_bus.write_enable, busy}, 0);
    clear_queues();
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Random mix
    for (int i = 0; i < 16; i++) begin
      r1 = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      run_op(f3_tab[$urandom_range(0, 5)], addr_tab[$urandom_range(0, 3)], r1,
             $urandom, 5'($urandom_range(0, 31)), -1);
    end

    repeat (4) @(posedge clk);
    #1;
    check_eq("results_drained", exp_q.size(), 0);
    check_eq("reads_drained", rexp_q.size(), 0);
    check_eq("writes_drained", wexp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
